sram_arb_ctrl: RTL

// - Two-requester arbiter/sequencer for the single-port synchronous SRAM (registered dout, 1-cycle read).
// - Accepts read/write requests from two masters, grants one at a time, drives SRAM cs_n/w_en/r_en/addr/din.
// - Returns read data to the granted master with a one-cycle rvalid strobe.
// - Sits between the masters and the SRAM instance; it is the only driver of the SRAM control pins.

---
 rtl/sram_arb_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-master arbiter and sequencer for a single-port synchronous SRAM
// with registered read data (1-cycle read).
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties);
// the default build arbitrates round-robin.
module sram_arb_ctrl #(
   parameter int unsigned ADDR_DEPTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_DEPTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_DEPTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  sram_cs_n,
   output logic                  sram_w_en,
   output logic                  sram_r_en,
   output logic [ADDR_DEPTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state;
   logic                    winner_c;   // 0 = master 0, 1 = master 1
   logic                    win_we_c;
   logic [ADDR_DEPTH-1:0]   win_addr_c;
   logic [DATA_WIDTH-1:0]   win_wdata_c;

   // Read data is the SRAM output register, passed straight through.
   assign rdata = sram_dout;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   // Fixed priority: master 0 wins whenever it is requesting.
   assign winner_c = !req0;
`else
   logic last_gnt;

   // Round-robin: a tie goes to the master that was not granted last.
   assign winner_c = (req0 && req1) ? !last_gnt : !req0;
`endif

   // Command fields of the selected master.
   assign win_we_c    = winner_c ? we1    : we0;
   assign win_addr_c  = winner_c ? addr1  : addr0;
   assign win_wdata_c = winner_c ? wdata1 : wdata0;

   // Sequencer: IDLE samples requests, ACCESS drives one SRAM command, RESP returns read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         sram_cs_n <= 1'b1;
         sram_w_en <= 1'b0;
         sram_r_en <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         last_gnt  <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state     <= ACCESS;
                  gnt0      <= !winner_c;
                  gnt1      <= winner_c;
                  sram_cs_n <= 1'b0;
                  sram_w_en <= win_we_c;
                  sram_r_en <= !win_we_c;
                  sram_addr <= win_addr_c;
                  sram_din  <= win_wdata_c;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                  last_gnt  <= winner_c;
`endif
               end
            end
            ACCESS: begin
               // gnt1 and sram_w_en still identify the owner and kind of this access.
               state     <= sram_w_en ? IDLE : RESP;
               rvalid0   <= sram_r_en && gnt0;
               rvalid1   <= sram_r_en && gnt1;
               gnt0      <= 1'b0;
               gnt1      <= 1'b0;
               sram_cs_n <= 1'b1;
               sram_w_en <= 1'b0;
               sram_r_en <= 1'b0;
            end
            RESP: begin
               state   <= IDLE;
               rvalid0 <= 1'b0;
               rvalid1 <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
